// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing the SoC peripheral bus between NumReq requesters, with address decode and error responses.
// Optional macros: PERIPH_ARB_TIMEOUT_EN (response timeout + drain), NEXYS_VIDEO (smaller DRAM window).
module periph_bus_arbiter #(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumReq-1:0]                     req_valid_i,
  output logic [NumReq-1:0]                     req_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]      req_addr_i,
  input  logic [NumReq-1:0]                     req_we_i,
  input  logic [NumReq-1:0][DataWidth-1:0]      req_wdata_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]    req_be_i,
  output logic [NumReq-1:0]                     rsp_valid_o,
  output logic [DataWidth-1:0]                  rsp_rdata_o,
  output logic                                  rsp_err_o,
  output logic                                  tgt_valid_o,
  input  logic                                  tgt_ready_i,
  output logic [10:0]                           tgt_sel_o,
  output logic [AddrWidth-1:0]                  tgt_addr_o,
  output logic                                  tgt_we_o,
  output logic [DataWidth-1:0]                  tgt_wdata_o,
  output logic [DataWidth/8-1:0]                tgt_be_o,
  input  logic                                  tgt_rsp_valid_i,
  input  logic [DataWidth-1:0]                  tgt_rdata_i,
  input  logic                                  tgt_err_i
);

  localparam int unsigned NumTgt = 11;
  localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [NumReq-1:0] OneReq = 1;

`ifdef NEXYS_VIDEO
  localparam logic [63:0] DramLen = 64'h2000_0000;
`else
  localparam logic [63:0] DramLen = 64'h4000_0000;
`endif

  localparam logic [63:0] TgtBase [NumTgt] = '{
    64'h8000_0000, 64'h4000_0000, 64'h3000_0000, 64'h2000_0000, 64'h1800_0000, 64'h1000_0000,
    64'h0C00_0000, 64'h0200_0000, 64'h0001_0000, 64'h3800_0000, 64'h0000_0000};
  localparam logic [63:0] TgtLen [NumTgt] = '{
    DramLen,       64'h1000,      64'h40,        64'h80_0000,   64'h1000,      64'h1000,
    64'h3FF_FFFF,  64'hC_0000,    64'h1_0000,    64'h4_0000,    64'h1000};

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DECERR
`ifdef PERIPH_ARB_TIMEOUT_EN
    , S_TOERR, S_DRAIN
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         rr_q, rr_d;
  logic [IdxW-1:0]         gnt_q;
  logic [AddrWidth-1:0]    addr_q;
  logic                    we_q;
  logic [DataWidth-1:0]    wdata_q;
  logic [DataWidth/8-1:0]  be_q;
  logic [NumTgt-1:0]       sel_q;
  logic [DataWidth-1:0]    rdata_q;
  logic                    err_q;

  logic                    gnt_found;
  logic [IdxW-1:0]         gnt_idx;
  logic [IdxW-1:0]         gnt_nxt;
  logic [IdxW-1:0]         cand [NumReq];
  logic [63:0]             dec_addr;
  logic [NumTgt-1:0]       hit;
  logic                    accept;
  logic                    capture;
  logic                    rsp_fire;

  // cand[k] is the k-th requester in priority order starting from the pointer.
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_cand
    assign cand[gi] = IdxW'((32'(rr_q) + 32'(gi)) % NumReq);
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (!gnt_found && req_valid_i[cand[k]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[k];
      end
    end
  end

  assign gnt_nxt  = IdxW'((32'(gnt_idx) + 32'd1) % NumReq);
  assign dec_addr = 64'(req_addr_i[gnt_idx]);

  // Offset compare avoids overflow of base+len.
  for (genvar gi = 0; gi < NumTgt; gi++) begin : g_dec
    assign hit[gi] = (dec_addr >= TgtBase[gi]) && ((dec_addr - TgtBase[gi]) < TgtLen[gi]);
  end

`ifdef PERIPH_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    accept  = 1'b0;
    capture = 1'b0;
`ifdef PERIPH_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          accept  = 1'b1;
          rr_d    = gnt_nxt;
          state_d = (|hit) ? S_ISSUE : S_DECERR;
        end
      end
      S_ISSUE: begin
        if (tgt_ready_i) begin
          state_d = S_WAIT;
`ifdef PERIPH_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        // A response in the limit cycle takes priority over the timeout.
        if (tgt_rsp_valid_i) begin
          capture = 1'b1;
          state_d = S_RESP;
        end
`ifdef PERIPH_ARB_TIMEOUT_EN
        else if (cnt_q == CntMax) begin
          state_d = S_TOERR;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      S_RESP:   state_d = S_IDLE;
      S_DECERR: state_d = S_IDLE;
`ifdef PERIPH_ARB_TIMEOUT_EN
      S_TOERR:  state_d = S_DRAIN;
      S_DRAIN: begin
        if (tgt_rsp_valid_i) state_d = S_IDLE;
      end
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (accept) begin
        gnt_q   <= gnt_idx;
        addr_q  <= req_addr_i[gnt_idx];
        we_q    <= req_we_i[gnt_idx];
        wdata_q <= req_wdata_i[gnt_idx];
        be_q    <= req_be_i[gnt_idx];
        sel_q   <= hit;
      end
      if (capture) begin
        rdata_q <= tgt_rdata_i;
        err_q   <= tgt_err_i;
      end
    end
  end

`ifdef PERIPH_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
  assign rsp_fire = (state_q == S_RESP) || (state_q == S_DECERR) || (state_q == S_TOERR);
`else
  assign rsp_fire = (state_q == S_RESP) || (state_q == S_DECERR);
`endif

  assign req_ready_o = (accept && !rst_i) ? (OneReq << gnt_idx) : '0;
  assign rsp_valid_o = rsp_fire ? (OneReq << gnt_q) : '0;
  assign rsp_err_o   = (state_q == S_RESP) ? err_q : rsp_fire;
  assign rsp_rdata_o = (state_q == S_RESP) ? rdata_q : '0;
  assign tgt_valid_o = (state_q == S_ISSUE);
  assign tgt_sel_o   = tgt_valid_o ? sel_q : '0;
  assign tgt_addr_o  = addr_q;
  assign tgt_we_o    = we_q;
  assign tgt_wdata_o = wdata_q;
  assign tgt_be_o    = be_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Self-checking bench for periph_bus_arbiter: vector table, hand-written corner sequences, random traffic vs. a transaction model.
module tb_periph_bus_arbiter;
  localparam int NR = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NR-1:0]            req_valid;
  logic [NR-1:0]            req_ready;
  logic [NR-1:0][AW-1:0]    req_addr;
  logic [NR-1:0]            req_we;
  logic [NR-1:0][DW-1:0]    req_wdata;
  logic [NR-1:0][DW/8-1:0]  req_be;
  logic [NR-1:0]            rsp_valid;
  logic [DW-1:0]            rsp_rdata;
  logic                     rsp_err;
  logic                     tgt_valid;
  logic                     tgt_ready;
  logic [10:0]              tgt_sel;
  logic [AW-1:0]            tgt_addr;
  logic                     tgt_we;
  logic [DW-1:0]            tgt_wdata;
  logic [DW/8-1:0]          tgt_be;
  logic                     tgt_rsp_valid;
  logic [DW-1:0]            tgt_rdata;
  logic                     tgt_err;

  periph_bus_arbiter #(.NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .tgt_valid_o(tgt_valid), .tgt_ready_i(tgt_ready), .tgt_sel_o(tgt_sel),
    .tgt_addr_o(tgt_addr), .tgt_we_o(tgt_we), .tgt_wdata_o(tgt_wdata), .tgt_be_o(tgt_be),
    .tgt_rsp_valid_i(tgt_rsp_valid), .tgt_rdata_i(tgt_rdata), .tgt_err_i(tgt_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [63:0] WKEY = 64'hA5A5_0000_5A5A_FFFF;

  // Memory map as the reference sees it.
  logic [63:0] m_base [11] = '{64'h8000_0000, 64'h4000_0000, 64'h3000_0000, 64'h2000_0000,
    64'h1800_0000, 64'h1000_0000, 64'h0C00_0000, 64'h0200_0000, 64'h1_0000, 64'h3800_0000, 64'h0};
`ifdef NEXYS_VIDEO
  logic [63:0] m_len [11] = '{64'h2000_0000, 64'h1000, 64'h40, 64'h80_0000, 64'h1000, 64'h1000,
    64'h3FF_FFFF, 64'hC_0000, 64'h1_0000, 64'h4_0000, 64'h1000};
`else
  logic [63:0] m_len [11] = '{64'h4000_0000, 64'h1000, 64'h40, 64'h80_0000, 64'h1000, 64'h1000,
    64'h3FF_FFFF, 64'hC_0000, 64'h1_0000, 64'h4_0000, 64'h1000};
`endif

  int rr_m = 0;

  function automatic logic [10:0] model_sel(input logic [63:0] a);
    logic [10:0] s = '0;
    for (int i = 0; i < 11; i++)
      if (a >= m_base[i] && a < m_base[i] + m_len[i]) s[i] = 1'b1;
    return s;
  endfunction

  function automatic int model_gnt(input logic [1:0] v);
    for (int k = 0; k < NR; k++) begin
      int i = (rr_m + k) % NR;
      if (v[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [63:0] rand_addr();
    int r = $urandom_range(0, 10);
    int m = $urandom_range(0, 4);
    case (m)
      0, 1:    return m_base[r] + (64'($urandom) % m_len[r]);
      2:       return m_base[r] + m_len[r];
      3:       return m_base[r] - 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One complete transaction, checked cycle by cycle from accept to response.
  task automatic do_txn(input logic [1:0] v, input logic [63:0] a0, input logic [63:0] a1,
                        input logic we, input int rdy_dly, input int rsp_dly,
                        input logic [63:0] rd, input logic terr, input int eg,
                        input logic [10:0] esel, input logic eerr, input logic [63:0] erd);
    logic [63:0] ea = (eg == 0) ? a0 : a1;
    @(negedge clk);
    req_valid    = v;
    req_addr[0]  = a0;
    req_addr[1]  = a1;
    req_we[eg]   = we;
    req_we[1-eg] = ~we;
    req_wdata[0] = a0 ^ WKEY;
    req_wdata[1] = a1 ^ WKEY;
    req_be[0]    = a0[7:0] ^ 8'h3C;
    req_be[1]    = a1[7:0] ^ 8'h3C;
    tgt_ready    = 1'b0;
    tgt_rsp_valid = 1'b0;
    #1;
    chk("req_ready", 64'(req_ready), 64'(2'b01 << eg));
    chk("tgt_valid_idle", 64'(tgt_valid), 64'd0);
    rr_m = (eg + 1) % NR;
    if (esel == '0) begin
      @(negedge clk);
      chk("decerr_valid", 64'(rsp_valid), 64'(2'b01 << eg));
      chk("decerr_err", 64'(rsp_err), 64'd1);
      chk("decerr_rdata", rsp_rdata, 64'd0);
      chk("decerr_tgt_valid", 64'(tgt_valid), 64'd0);
    end else begin
      for (int d = 0; d <= rdy_dly; d++) begin
        @(negedge clk);
        tgt_ready = (d == rdy_dly);
        chk("issue_valid", 64'(tgt_valid), 64'd1);
        chk("issue_sel", 64'(tgt_sel), 64'(esel));
        chk("issue_addr", tgt_addr, ea);
        chk("issue_rsp", 64'(rsp_valid), 64'd0);
        if (d == 0) begin
          chk("issue_we", 64'(tgt_we), 64'(we));
          chk("issue_wdata", tgt_wdata, ea ^ WKEY);
          chk("issue_be", 64'(tgt_be), 64'(ea[7:0] ^ 8'h3C));
        end
      end
      for (int d = 0; d <= rsp_dly; d++) begin
        @(negedge clk);
        tgt_ready     = 1'b0;
        tgt_rsp_valid = (d == rsp_dly);
        tgt_rdata     = (d == rsp_dly) ? rd : ~rd;
        tgt_err       = (d == rsp_dly) ? terr : ~terr;
        chk("wait_tgt_valid", 64'(tgt_valid), 64'd0);
        chk("wait_sel", 64'(tgt_sel), 64'd0);
        chk("wait_rsp", 64'(rsp_valid), 64'd0);
      end
      @(negedge clk);
      tgt_rsp_valid = 1'b0;
      chk("resp_valid", 64'(rsp_valid), 64'(2'b01 << eg));
      chk("resp_err", 64'(rsp_err), 64'(eerr));
      chk("resp_rdata", rsp_rdata, erd);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rdata"}, rsp_rdata, 64'd0);
    chk({tag, "_err"}, 64'(rsp_err), 64'd0);
    chk({tag, "_tgt_valid"}, 64'(tgt_valid), 64'd0);
    chk({tag, "_sel"}, 64'(tgt_sel), 64'd0);
    chk({tag, "_addr"}, tgt_addr, 64'd0);
    chk({tag, "_wdata"}, tgt_wdata, 64'd0);
    chk({tag, "_we_be"}, 64'({tgt_we, tgt_be}), 64'd0);
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [63:0] a0, a1;
    logic        we;
    int          rdy, rsp;
    logic [63:0] rd;
    logic        terr;
    int          g;
    logic [10:0] sel;
    logic        err;
    logic [63:0] erd;
  } vec_t;

  vec_t tbl [19];

  initial begin
    tbl[0]  = '{2'b01, 64'h1000_0000, 64'h0,          1'b0, 0, 1, 64'hA5, 1'b0, 0, 11'h020, 1'b0, 64'hA5};
    tbl[1]  = '{2'b11, 64'h4000_0000, 64'h4000_0008,  1'b1, 0, 0, 64'h11, 1'b0, 1, 11'h002, 1'b0, 64'h11};
    tbl[2]  = '{2'b11, 64'h4000_0000, 64'h4000_0008,  1'b1, 0, 0, 64'h22, 1'b0, 0, 11'h002, 1'b0, 64'h22};
    tbl[3]  = '{2'b11, 64'h4000_0000, 64'h4000_0008,  1'b1, 0, 0, 64'h33, 1'b0, 1, 11'h002, 1'b0, 64'h33};
    tbl[4]  = '{2'b11, 64'h4000_0000, 64'h4000_0008,  1'b1, 0, 0, 64'h44, 1'b0, 0, 11'h002, 1'b0, 64'h44};
    tbl[5]  = '{2'b11, 64'h4000_0000, 64'h4000_0008,  1'b1, 0, 0, 64'h55, 1'b0, 1, 11'h002, 1'b0, 64'h55};
    tbl[6]  = '{2'b10, 64'h0,         64'h5000_0000,  1'b0, 0, 0, 64'h66, 1'b0, 1, 11'h000, 1'b1, 64'h0};
    tbl[7]  = '{2'b01, 64'hC000_0000, 64'h0,          1'b1, 0, 0, 64'h67, 1'b0, 0, 11'h000, 1'b1, 64'h0};
    tbl[8]  = '{2'b01, 64'h9FFF_FFF8, 64'h0,          1'b0, 5, 2, 64'h1122_3344_5566_7788, 1'b1, 0, 11'h001, 1'b1, 64'h1122_3344_5566_7788};
    tbl[9]  = '{2'b01, 64'hFFF,       64'h0,          1'b0, 1, 0, 64'h77, 1'b0, 0, 11'h400, 1'b0, 64'h77};
    tbl[10] = '{2'b10, 64'h0,         64'h1000,       1'b0, 0, 0, 64'h88, 1'b0, 1, 11'h000, 1'b1, 64'h0};
    tbl[11] = '{2'b01, 64'h0FFF_FFFE, 64'h0,          1'b1, 0, 0, 64'h99, 1'b0, 0, 11'h040, 1'b0, 64'h99};
    tbl[12] = '{2'b11, 64'h0FFF_FFFF, 64'h3000_003F,  1'b1, 2, 3, 64'hAA, 1'b0, 1, 11'h004, 1'b0, 64'hAA};
    tbl[13] = '{2'b11, 64'h0FFF_FFFF, 64'h0,          1'b0, 0, 0, 64'hAB, 1'b0, 0, 11'h000, 1'b1, 64'h0};
    tbl[14] = '{2'b10, 64'h0,         64'h3803_FFFF,  1'b0, 0, 1, 64'hBB, 1'b0, 1, 11'h200, 1'b0, 64'hBB};
    tbl[15] = '{2'b01, 64'h1_FFFF,    64'h0,          1'b0, 0, 0, 64'hCC, 1'b0, 0, 11'h100, 1'b0, 64'hCC};
    tbl[16] = '{2'b10, 64'h0,         64'h020B_FFFF,  1'b1, 1, 0, 64'hDD, 1'b0, 1, 11'h080, 1'b0, 64'hDD};
    tbl[17] = '{2'b01, 64'h207F_FFFF, 64'h0,          1'b0, 0, 2, 64'hEE, 1'b0, 0, 11'h008, 1'b0, 64'hEE};
    tbl[18] = '{2'b10, 64'h0,         64'h1800_0000,  1'b0, 0, 0, 64'hFF, 1'b0, 1, 11'h010, 1'b0, 64'hFF};

    rst = 1'b1;
    req_valid = '0; req_addr = '0; req_we = '0; req_wdata = '0; req_be = '0;
    tgt_ready = 1'b0; tgt_rsp_valid = 1'b0; tgt_rdata = '0; tgt_err = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    foreach (tbl[i])
      do_txn(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].we, tbl[i].rdy, tbl[i].rsp,
             tbl[i].rd, tbl[i].terr, tbl[i].g, tbl[i].sel, tbl[i].err, tbl[i].erd);

    // Reset in WAIT_RSP abandons the transaction and its late response.
    @(negedge clk);
    req_valid = 2'b01; req_addr[0] = 64'h4000_0000;
    #1 chk("rst_seq_grant", 64'(req_ready), 64'(2'b01 << model_gnt(2'b01)));
    @(negedge clk);
    tgt_ready = 1'b1; req_valid = '0;
    @(negedge clk);
    tgt_ready = 1'b0; rst = 1'b1; req_valid = 2'b11;
    @(negedge clk);
    tgt_rsp_valid = 1'b1; tgt_rdata = 64'hDEAD; tgt_err = 1'b1;
    #1 chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0; req_valid = '0;
    @(negedge clk);
    tgt_rsp_valid = 1'b0;
    chk("late_rsp_ignored", 64'(rsp_valid), 64'd0);
    rr_m = 0;
    do_txn(2'b11, 64'h4000_0010, 64'h4000_0020, 1'b0, 0, 0, 64'h5, 1'b0, 0, 11'h002, 1'b0, 64'h5);

`ifdef PERIPH_ARB_TIMEOUT_EN
    // Silent target: timeout pulse after TO WAIT_RSP cycles, then a drain with no grants.
    @(negedge clk);
    req_valid = 2'b10; req_addr[1] = 64'h4000_0000;
    #1 chk("to_grant", 64'(req_ready), 64'(2'b01 << model_gnt(2'b10)));
    rr_m = 0;
    @(negedge clk);
    tgt_ready = 1'b1; req_valid = '0;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      tgt_ready = 1'b0;
      chk("to_wait", 64'(rsp_valid), 64'd0);
    end
    @(negedge clk);
    chk("to_valid", 64'(rsp_valid), 64'b10);
    chk("to_err", 64'(rsp_err), 64'd1);
    chk("to_rdata", rsp_rdata, 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid = 2'b01; req_addr[0] = 64'h4000_0000;
      tgt_rsp_valid = (k == 2);
      #1;
      chk("drain_nogrant", 64'(req_ready), 64'd0);
      chk("drain_rsp", 64'(rsp_valid), 64'd0);
    end
    do_txn(2'b01, 64'h4000_0000, 64'h0, 1'b1, 0, 0, 64'h6, 1'b0, 0, 11'h002, 1'b0, 64'h6);
`else
    // Without the timeout a slow target is simply waited for.
    do_txn(2'b01, 64'h4000_0000, 64'h0, 1'b0, 0, 20, 64'h7, 1'b0, model_gnt(2'b01), 11'h002, 1'b0, 64'h7);
`endif

    for (int n = 0; n < 40; n++) begin
      logic [1:0]  v   = 2'($urandom_range(1, 3));
      logic [63:0] a0  = rand_addr();
      logic [63:0] a1  = rand_addr();
      int          g   = model_gnt(v);
      logic [10:0] s   = model_sel((g == 0) ? a0 : a1);
      logic [63:0] rd  = {$urandom, $urandom};
      logic        te  = 1'($urandom_range(0, 1));
      do_txn(v, a0, a1, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 4),
             rd, te, g, s, (s == '0) ? 1'b1 : te, (s == '0) ? 64'd0 : rd);
    end

    @(negedge clk);
    req_valid = '0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end
endmodule
